// File: rtl/imem_resp_pkg.sv
// Constants, state encoding and register record for the instruction-memory responder.
package imem_resp_pkg;

  localparam int unsigned DepthLog2Default = 14;
  localparam int unsigned WaitDefault      = 1;
  localparam int unsigned InvCycDefault    = 4;
  localparam int unsigned CntW             = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StInv
  } state_e;

  typedef struct packed {
    state_e            state;
    logic [CntW-1:0]   counter;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              fence;
  } reg_type;

endpackage

// File: rtl/imem_wires_pkg.sv
// Request/response bundles shared by every memory port in the core.
package imem_wires_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;

endpackage

// File: rtl/imem_ram.sv
// Synchronous-read, byte-write 32-bit RAM; a same-cycle write to the read word is forwarded.
module imem_ram #(
  parameter int unsigned DEPTH_LOG2 = 14
) (
  input  logic                  clock,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (re) begin
        rdata_q[8*i +: 8] <= (we[i] && (waddr == raddr)) ? wdata[8*i +: 8]
                                                           : mem[raddr][8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_resp.sv
// Instruction-memory responder: fixed wait states, optional fence invalidate delay, one
// mem_ready pulse per accepted request.
module imem_resp
  import imem_wires_pkg::*;
  import imem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DepthLog2Default,
  parameter int unsigned WAIT       = WaitDefault,
  parameter int unsigned INV_CYC    = InvCycDefault
) (
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out
);

  reg_type               r, r_d;
  logic                  accept;
  logic                  active;
  logic                  ram_re;
  logic [3:0]            ram_we;
  logic [DEPTH_LOG2-1:0] ram_raddr;
  logic [31:0]           ram_rdata;

  always_comb begin
    r_d    = r;
    accept = 1'b0;
    unique case (r.state)
      StIdle: accept = imem_in.mem_valid;
      StResp: begin
        accept    = imem_in.mem_valid;
        r_d.state = StIdle;
      end
      StWait: begin
        r_d.counter = r.counter - CntW'(1);
        if (r.counter <= CntW'(1)) begin
          r_d.state   = StResp;
          r_d.counter = '0;
        end
      end
      StInv: begin
        if (r.counter == '0) begin
          if (WAIT > 0) begin
            r_d.state   = StWait;
            r_d.counter = CntW'(WAIT);
          end else begin
            r_d.state = StResp;
          end
        end else begin
          r_d.counter = r.counter - CntW'(1);
        end
      end
      default: r_d.state = StIdle;
    endcase

    if (accept) begin
      r_d.addr  = imem_in.mem_addr;
      r_d.wdata = imem_in.mem_wdata;
      r_d.wstrb = imem_in.mem_wstrb;
      r_d.fence = imem_in.mem_fence;
      if (imem_in.mem_fence) begin
        r_d.state   = StInv;
        r_d.counter = CntW'(INV_CYC - 1);
      end else if (WAIT > 0) begin
        r_d.state   = StWait;
        r_d.counter = CntW'(WAIT);
      end else begin
        r_d.state   = StResp;
        r_d.counter = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r <= '0;
    end else begin
      r <= r_d;
    end
  end

  // Reset gating keeps a request caught mid-flight from pulsing ready or writing RAM.
  assign active    = reset && (r.state == StResp);
  assign ram_re    = reset && (r_d.state == StResp);
  assign ram_we    = active ? r.wstrb : 4'b0000;
  assign ram_raddr = accept ? imem_in.mem_addr[DEPTH_LOG2+1:2] : r.addr[DEPTH_LOG2+1:2];

  imem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clock(clock),
    .re   (ram_re),
    .raddr(ram_raddr),
    .we   (ram_we),
    .waddr(r.addr[DEPTH_LOG2+1:2]),
    .wdata(r.wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    imem_out           = '0;
    imem_out.mem_ready = active;
    if (active) begin
      imem_out.mem_rdata = ram_rdata;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{imem_in.mem_spec, imem_in.mem_instr,
                         imem_in.mem_addr[31:DEPTH_LOG2+2], imem_in.mem_addr[1:0],
                         r.addr[31:DEPTH_LOG2+2], r.addr[1:0], r.fence};

endmodule

// File: tb/tb_imem_resp.sv
// Scoreboard bench: two responders (WAIT=1/INV_CYC=4 and WAIT=0/INV_CYC=2) share one driver.
module tb_imem_resp;
  import imem_wires_pkg::*;

  localparam int unsigned Words = 256;

  typedef struct {
    int          d;
    logic [31:0] data;
    bit          known;
    int unsigned due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  mem_in_type  req;
  int          sel;
  mem_in_type  in0, in1;
  mem_out_type out0, out1;

  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          junk_en;
  exp_t        exp_q[$];
  int unsigned next_free [2];
  logic [31:0] mdl [2][Words];
  bit          known [2][Words];

  function automatic mem_in_type gate(input mem_in_type r, input bit en);
    mem_in_type g;
    g = r;
    g.mem_valid = r.mem_valid & en;
    return g;
  endfunction

  assign in0 = gate(req, sel == 0);
  assign in1 = gate(req, sel == 1);

  imem_resp #(.DEPTH_LOG2(14), .WAIT(0), .INV_CYC(2)) dut0 (
    .reset(reset), .clock(clock), .imem_in(in0), .imem_out(out0)
  );
  imem_resp #(.DEPTH_LOG2(14), .WAIT(1), .INV_CYC(4)) dut1 (
    .reset(reset), .clock(clock), .imem_in(in1), .imem_out(out1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d exceeded limit 60000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp_v, cyc);
    end
  endfunction

  // Latency from acceptance to mem_ready, straight from the timing rules.
  function automatic int unsigned lat_of(input int d, input bit fence);
    int unsigned w, inv;
    w   = (d == 1) ? 1 : 0;
    inv = (d == 1) ? 4 : 2;
    return w + 1 + (fence ? inv : 0);
  endfunction

  always @(negedge clock) begin
    mem_out_type o;
    exp_t        e;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        o = (d == 0) ? out0 : out1;
        if (o.mem_ready) begin
          if (exp_q.size() == 0) begin
            check("ready_unexpected", 32'(o.mem_ready), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ready_dut", 32'(d), 32'(e.d));
            check("ready_cycle", cyc, e.due);
            if (e.known) check("rdata", o.mem_rdata, e.data);
          end
        end else begin
          check("rdata_idle_zero", o.mem_rdata, 32'd0);
        end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        check("ready_timeout", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic issue(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input bit fence);
    int unsigned w;
    exp_t        e;
    if (sel != d) drain();
    sel = d;
    // While busy, optionally toss in valid pulses that must be ignored.
    while (cyc < next_free[d]) begin
      req = '0;
      if (junk_en && $urandom_range(1, 0) == 1) begin
        req.mem_valid = 1'b1;
        req.mem_addr  = $urandom;
        req.mem_wdata = $urandom;
        req.mem_wstrb = 4'hF;
        req.mem_fence = 1'($urandom_range(1, 0));
      end
      tick();
    end
    w = 32'(addr[9:2]);
    req           = '0;
    req.mem_valid = 1'b1;
    req.mem_fence = fence;
    req.mem_spec  = 1'($urandom_range(1, 0));
    req.mem_instr = 1'($urandom_range(1, 0));
    req.mem_addr  = addr;
    req.mem_wdata = wdata;
    req.mem_wstrb = wstrb;
    e.d     = d;
    e.data  = mdl[d][w];
    e.known = known[d][w];
    e.due   = cyc + lat_of(d, fence);
    exp_q.push_back(e);
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) mdl[d][w][8*b +: 8] = wdata[8*b +: 8];
    end
    if (wstrb == 4'hF) known[d][w] = 1'b1;
    next_free[d] = e.due;
    tick();
    req.mem_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] old;
    bit          oldk;
    logic [31:0] a;
    int unsigned r;
    req = '0;
    sel = 0;
    junk_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      next_free[d] = 0;
      for (int w = 0; w < Words; w++) known[d][w] = 1'b0;
    end

    @(posedge clock);
    #1;
    mon_en = 1'b1;
    tick();
    tick();
    check("reset_ready0", 32'(out0.mem_ready), 32'd0);
    check("reset_ready1", 32'(out1.mem_ready), 32'd0);
    check("reset_rdata1", out1.mem_rdata, 32'd0);
    reset = 1'b1;

    // Fill the modelled region of both RAMs.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < Words; w++) begin
        issue(d, 32'(w) << 2, (d == 1 && w == 64) ? 32'hDEAD_BEEF : $urandom, 4'hF, 1'b0);
      end
    end

    issue(1, 32'h100, 32'h0, 4'h0, 1'b0);

    drain();
    issue(0, 32'h0, 32'h0, 4'h0, 1'b0);
    issue(0, 32'h4, 32'h0, 4'h0, 1'b0);
    issue(0, 32'h8, 32'h0, 4'h0, 1'b0);
    issue(0, 32'hC, 32'h0, 4'h0, 1'b0);

    for (int d = 0; d < 2; d++) begin
      issue(d, 32'h40, 32'hAAAA_AAAA, 4'hF, 1'b0);
      issue(d, 32'h40, 32'h1122_3344, 4'b0101, 1'b0);
      issue(d, 32'h40, 32'h0, 4'h0, 1'b0);
    end

    junk_en = 1'b1;
    issue(1, 32'h20, 32'h0, 4'h0, 1'b1);
    issue(1, 32'h24, 32'h0, 4'h0, 1'b0);
    issue(1, 32'h28, 32'h0, 4'h0, 1'b1);
    junk_en = 1'b0;

    issue(1, 32'h1_0000, 32'h0, 4'h0, 1'b0);
    issue(1, 32'h0, 32'h0, 4'h0, 1'b0);
    issue(1, 32'h103, 32'h0, 4'h0, 1'b0);
    issue(1, 32'h100, 32'h0, 4'h0, 1'b0);

    // Reset lands while a write sits in wait: it must vanish without touching RAM.
    drain();
    old  = mdl[1][48];
    oldk = known[1][48];
    issue(1, 32'hC0, 32'h1234_5678, 4'hF, 1'b0);
    mdl[1][48]   = old;
    known[1][48] = oldk;
    void'(exp_q.pop_back());
    reset = 1'b0;
    tick();
    check("reset_mid_ready", 32'(out1.mem_ready), 32'd0);
    tick();
    check("reset_mid_rdata", out1.mem_rdata, 32'd0);
    reset = 1'b1;
    next_free[1] = cyc;
    issue(1, 32'hC0, 32'h0, 4'h0, 1'b0);
    issue(1, 32'h100, 32'h0, 4'h0, 1'b0);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 300; n++) begin
        a = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(Words - 1, 0)) << 2);
        r = $urandom_range(9, 0);
        junk_en = ($urandom_range(3, 0) == 0);
        if (r < 5)      issue(d, a, 32'h0, 4'h0, 1'b0);
        else if (r < 8) issue(d, a, $urandom, 4'($urandom), 1'b0);
        else            issue(d, a, 32'h0, 4'h0, 1'b1);
        if ($urandom_range(3, 0) == 0) begin
          repeat ($urandom_range(3, 1)) tick();
        end
      end
    end
    junk_en = 1'b0;
    drain();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
